// File: rtl/l2_pkg.sv
// Shared types for the set-associative L2: FSM states, requester ids, width helper.
// Latency/backpressure: n/a (types only).
package l2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT_AW,
    ST_EVICT_W,
    ST_AR,
    ST_R,
    ST_INSTALL,
    ST_RESP
  } l2_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } l2_port_e;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l2_victim_sel.sv
// Victim choice for one set: lowest invalid way, else the set's round-robin pointer.
// Combinational pick; pointer advances on i_adv only when the set is full.
module l2_victim_sel
  import l2_pkg::*;
#(
  parameter int SETS = 64,
  parameter int WAYS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [idx_bits(SETS)-1:0] i_idx,
  input  logic [WAYS-1:0]           i_valid,
  input  logic                      i_adv,
  output logic [idx_bits(WAYS)-1:0] o_way
);

  localparam int WAY_W = idx_bits(WAYS);

  logic [WAY_W-1:0] r_rr [SETS];
  logic             w_full;

  assign w_full = &i_valid;

  always_comb begin
    o_way = r_rr[i_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) o_way = WAY_W'(w);
    end
  end

  // WAYS is a power of two, so the natural wrap is the mod-WAYS increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else if (i_adv && w_full) begin
      r_rr[i_idx] <= r_rr[i_idx] + 1'b1;
    end
  end

endmodule

// File: rtl/l2_assoc.sv
// Blocking N-way write-back/write-allocate L2 for i$/d$; hit responds 2 cycles after accept.
// One request in flight; ready_o only in IDLE; bus valids held until handshake. L2_RR_ARB_EN: RR i$/d$ arbitration.
module l2_assoc
  import l2_pkg::*;
#(
  parameter int SETS   = 64,
  parameter int WAYS   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_valid_i,
  output logic              icache_ready_o,
  input  logic [31:0]       icache_addr_i,
  output logic              icache_valid_o,
  output logic [DATA_W-1:0] icache_dat_o,
  input  logic              dcache_valid_i,
  output logic              dcache_ready_o,
  input  logic [31:0]       dcache_addr_i,
  input  logic              dcache_we_i,
  input  logic [DATA_W-1:0] dcache_dat_i,
  output logic              dcache_valid_o,
  output logic [DATA_W-1:0] dcache_dat_o,
  output logic              l2_req_if_arvalid,
  input  logic              l2_req_if_arready,
  output logic [31:0]       l2_req_if_ar,
  output logic              l2_req_if_awvalid,
  input  logic              l2_req_if_awready,
  output logic [31:0]       l2_req_if_aw,
  output logic              l2_req_if_wvalid,
  input  logic              l2_req_if_wready,
  output logic [DATA_W-1:0] l2_req_if_w,
  input  logic              l2_resp_if_rvalid,
  output logic              l2_resp_if_rready,
  input  logic [DATA_W-1:0] l2_resp_if_r
);

  localparam int IDX_W = idx_bits(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = idx_bits(WAYS);
  localparam int PAD_W = 32 - ADDR_W;

  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];
  logic [WAYS-1:0]   r_vld   [SETS];
  logic [WAYS-1:0]   r_dirty [SETS];

  l2_state_e         r_state, w_nxt;
  l2_port_e          r_port, w_acc_port;
  logic              r_run, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdat, r_rdat;
  logic [WAY_W-1:0]  r_vic, w_vic_way, w_hit_way;
  logic              w_hit, w_i_pri, w_idle, w_acc_i, w_acc_d, w_acc;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WAYS-1:0]   w_set_vld;
  logic              w_unused_addr;

  assign w_unused_addr = ^{icache_addr_i[31:ADDR_W], dcache_addr_i[31:ADDR_W]};

  assign w_idx     = r_addr[IDX_W-1:0];
  assign w_tag     = r_addr[ADDR_W-1:IDX_W];
  assign w_set_vld = r_vld[w_idx];

`ifdef L2_RR_ARB_EN
  l2_port_e r_last;
  // Starting from "d$ granted last" makes i$ win the first collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_last <= PORT_D;
    else if (w_acc) r_last <= w_acc_port;
  end
  assign w_i_pri = (r_last == PORT_D);
`else
  assign w_i_pri = 1'b1;
`endif

  assign w_idle         = (r_state == ST_IDLE) && r_run;
  assign icache_ready_o = w_idle && (w_i_pri || !dcache_valid_i);
  assign dcache_ready_o = w_idle && !(icache_valid_i && w_i_pri);
  assign w_acc_i        = icache_valid_i && icache_ready_o;
  assign w_acc_d        = dcache_valid_i && dcache_ready_o && !w_acc_i;
  assign w_acc          = w_acc_i || w_acc_d;
  assign w_acc_port     = w_acc_i ? PORT_I : PORT_D;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_set_vld[w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  l2_victim_sel #(.SETS(SETS), .WAYS(WAYS)) u_victim (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_idx   (w_idx),
    .i_valid (w_set_vld),
    .i_adv   ((r_state == ST_LOOKUP) && !w_hit),
    .o_way   (w_vic_way)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_acc) w_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (w_hit)                                                    w_nxt = ST_RESP;
        else if (w_set_vld[w_vic_way] && r_dirty[w_idx][w_vic_way])   w_nxt = ST_EVICT_AW;
        else if (r_we)                                                w_nxt = ST_INSTALL;
        else                                                          w_nxt = ST_AR;
      end
      ST_EVICT_AW: if (l2_req_if_awready) w_nxt = ST_EVICT_W;
      ST_EVICT_W:  if (l2_req_if_wready)  w_nxt = r_we ? ST_INSTALL : ST_AR;
      ST_AR:       if (l2_req_if_arready) w_nxt = ST_R;
      ST_R:        if (l2_resp_if_rvalid) w_nxt = ST_RESP;
      ST_INSTALL:  w_nxt = ST_RESP;
      ST_RESP:     w_nxt = ST_IDLE;
      default:     w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
      r_port  <= PORT_I;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_vic   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_vld[s]   <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      r_state <= w_nxt;
      r_run   <= 1'b1;
      if ((r_state == ST_IDLE) && w_acc) begin
        r_port <= w_acc_port;
        r_we   <= w_acc_d && dcache_we_i;
        r_addr <= w_acc_i ? icache_addr_i[ADDR_W-1:0] : dcache_addr_i[ADDR_W-1:0];
        r_wdat <= dcache_dat_i;
      end
      if (r_state == ST_LOOKUP) begin
        if (w_hit) begin
          r_rdat <= r_we ? r_wdat : r_data[w_idx][w_hit_way];
          if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
        end else begin
          r_vic <= w_vic_way;
        end
      end
      if ((r_state == ST_R) && l2_resp_if_rvalid) begin
        r_rdat               <= l2_resp_if_r;
        r_vld[w_idx][r_vic]   <= 1'b1;
        r_dirty[w_idx][r_vic] <= 1'b0;
      end
      if (r_state == ST_INSTALL) begin
        r_rdat               <= r_wdat;
        r_vld[w_idx][r_vic]   <= 1'b1;
        r_dirty[w_idx][r_vic] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: every read is qualified by r_vld.
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOOKUP) && w_hit && r_we) r_data[w_idx][w_hit_way] <= r_wdat;
    if ((r_state == ST_R) && l2_resp_if_rvalid) begin
      r_tag[w_idx][r_vic]  <= w_tag;
      r_data[w_idx][r_vic] <= l2_resp_if_r;
    end
    if (r_state == ST_INSTALL) begin
      r_tag[w_idx][r_vic]  <= w_tag;
      r_data[w_idx][r_vic] <= r_wdat;
    end
  end

  assign icache_valid_o    = (r_state == ST_RESP) && (r_port == PORT_I);
  assign dcache_valid_o    = (r_state == ST_RESP) && (r_port == PORT_D);
  assign icache_dat_o      = icache_valid_o ? r_rdat : '0;
  assign dcache_dat_o      = dcache_valid_o ? r_rdat : '0;

  assign l2_req_if_arvalid = (r_state == ST_AR);
  assign l2_req_if_ar      = l2_req_if_arvalid ? {{PAD_W{1'b0}}, r_addr} : '0;
  assign l2_req_if_awvalid = (r_state == ST_EVICT_AW);
  assign l2_req_if_aw      = l2_req_if_awvalid ? {{PAD_W{1'b0}}, r_tag[w_idx][r_vic], w_idx} : '0;
  assign l2_req_if_wvalid  = (r_state == ST_EVICT_W);
  assign l2_req_if_w       = l2_req_if_wvalid ? r_data[w_idx][r_vic] : '0;
  assign l2_resp_if_rready = (r_state == ST_R);

endmodule

// File: tb/tb_l2_assoc.sv
// Directed bench for l2_assoc: vector table of single requests plus hand sequences
// for bus stalls, eviction stall, i$/d$ collision ordering and reset during refill.
module tb_l2_assoc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_valid_i = 1'b0, icache_ready_o, icache_valid_o;
  logic [31:0] icache_addr_i = '0, icache_dat_o;
  logic        dcache_valid_i = 1'b0, dcache_ready_o, dcache_valid_o, dcache_we_i = 1'b0;
  logic [31:0] dcache_addr_i = '0, dcache_dat_i = '0, dcache_dat_o;
  logic        arvalid, awvalid, wvalid, rready;
  logic [31:0] ar, aw, w, rdat;
  logic        ar_en = 1'b1, aw_en = 1'b1, w_en = 1'b1, r_en = 1'b1;

  int          n_pass = 0, n_tot = 0, cyc = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] ar_addr = '0, aw_addr = '0, w_last = '0, ar_seen = '0;
  logic [2:0]  order = '0;

  l2_assoc dut (
    .clk(clk), .rst_n(rst_n),
    .icache_valid_i(icache_valid_i), .icache_ready_o(icache_ready_o), .icache_addr_i(icache_addr_i),
    .icache_valid_o(icache_valid_o), .icache_dat_o(icache_dat_o),
    .dcache_valid_i(dcache_valid_i), .dcache_ready_o(dcache_ready_o), .dcache_addr_i(dcache_addr_i),
    .dcache_we_i(dcache_we_i), .dcache_dat_i(dcache_dat_i),
    .dcache_valid_o(dcache_valid_o), .dcache_dat_o(dcache_dat_o),
    .l2_req_if_arvalid(arvalid), .l2_req_if_arready(ar_en), .l2_req_if_ar(ar),
    .l2_req_if_awvalid(awvalid), .l2_req_if_awready(aw_en), .l2_req_if_aw(aw),
    .l2_req_if_wvalid(wvalid), .l2_req_if_wready(w_en), .l2_req_if_w(w),
    .l2_resp_if_rvalid(r_en), .l2_resp_if_rready(rready), .l2_resp_if_r(rdat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h41) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  assign rdat = mem_data(ar_seen);

  // Bus monitor; knobs only change just after a rising edge, so a negedge sample
  // sees exactly what the next rising edge will handshake.
  always @(negedge clk) begin
    if (arvalid) ar_seen = ar;
    if (arvalid && ar_en) begin ar_cnt++; ar_addr = ar; end
    if (awvalid && aw_en) begin aw_cnt++; aw_addr = aw; end
    if (wvalid && w_en)   begin w_cnt++;  w_last = w;   end
    if (icache_valid_o) order = {order[1:0], 1'b0};
    if (dcache_valid_o) order = {order[1:0], 1'b1};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdat, output int t0);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    if (port) begin
      dcache_valid_i = 1'b1; dcache_we_i = we; dcache_addr_i = addr; dcache_dat_i = wdat;
    end else begin
      icache_valid_i = 1'b1; icache_addr_i = addr;
    end
    for (int k = 0; k < 100 && !acc; k++) begin
      #1;
      if ((port ? dcache_ready_o : icache_ready_o) === 1'b1) acc = 1'b1;
      else @(negedge clk);
    end
    chk(port ? "accept_d" : "accept_i", acc, 1);
    if (acc) @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    if (port) dcache_valid_i = 1'b0;
    else      icache_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input logic port, output logic [31:0] dat, output int tr);
    bit ok;
    ok = 1'b0; dat = '0; tr = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if ((port ? dcache_valid_o : icache_valid_o) === 1'b1) begin
        ok = 1'b1; dat = port ? dcache_dat_o : icache_dat_o; tr = cyc;
      end
    end
    chk(port ? "resp_seen_d" : "resp_seen_i", ok, 1);
  endtask

  task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdat, output logic [31:0] dat, output int lat);
    int t0, tr;
    issue(port, we, addr, wdat, t0);
    wait_resp(port, dat, tr);
    lat = tr - t0;
  endtask

  task automatic port_seq(input logic port, input int n, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] dat;
    int lat;
    for (int i = 0; i < n; i++) begin
      do_req(port, 1'b0, addr, '0, dat, lat);
      chk(port ? "coll_dat_d" : "coll_dat_i", dat, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_dat;
    logic        exp_ar;
    logic [31:0] exp_ar_addr;
    logic        exp_aw;
    logic [31:0] exp_aw_addr;
    logic [31:0] exp_w;
    logic        exp_hit;
  } vec_t;

  localparam int NV = 17;
  vec_t v [NV];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] dat;
    int lat, t0, tr, a0, aw0, w0;
    bit seen;

    //          port  we    addr    wdat          exp_dat       ar    ar_addr  aw    aw_addr  w             hit
    v[0]  = '{1'b0, 1'b0, 32'h41,  32'h0,        32'hDEADBEEF, 1'b1, 32'h41,  1'b0, 32'h0,   32'h0,        1'b0};
    v[1]  = '{1'b0, 1'b0, 32'h41,  32'h0,        32'hDEADBEEF, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1};
    v[2]  = '{1'b1, 1'b1, 32'h05,  32'h12345678, 32'h12345678, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0};
    v[3]  = '{1'b1, 1'b0, 32'h05,  32'h0,        32'h12345678, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1};
    v[4]  = '{1'b1, 1'b1, 32'h05,  32'h55550005, 32'h55550005, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1};
    v[5]  = '{1'b1, 1'b1, 32'h45,  32'h00450045, 32'h00450045, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0};
    v[6]  = '{1'b1, 1'b1, 32'h85,  32'h00850085, 32'h00850085, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0};
    v[7]  = '{1'b1, 1'b1, 32'hC5,  32'h00C500C5, 32'h00C500C5, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0};
    v[8]  = '{1'b1, 1'b1, 32'h105, 32'h01050105, 32'h01050105, 1'b0, 32'h0,   1'b1, 32'h05,  32'h55550005, 1'b0};
    v[9]  = '{1'b1, 1'b1, 32'h145, 32'h01450145, 32'h01450145, 1'b0, 32'h0,   1'b1, 32'h45,  32'h00450045, 1'b0};
    v[10] = '{1'b1, 1'b0, 32'h105, 32'h0,        32'h01050105, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1};
    v[11] = '{1'b1, 1'b0, 32'h45,  32'h0,        32'hC0DE0045, 1'b1, 32'h45,  1'b1, 32'h85,  32'h00850085, 1'b0};
    v[12] = '{1'b0, 1'b0, 32'h07,  32'h0,        32'hC0DE0007, 1'b1, 32'h07,  1'b0, 32'h0,   32'h0,        1'b0};
    v[13] = '{1'b0, 1'b0, 32'h47,  32'h0,        32'hC0DE0047, 1'b1, 32'h47,  1'b0, 32'h0,   32'h0,        1'b0};
    v[14] = '{1'b0, 1'b0, 32'h87,  32'h0,        32'hC0DE0087, 1'b1, 32'h87,  1'b0, 32'h0,   32'h0,        1'b0};
    v[15] = '{1'b0, 1'b0, 32'hC7,  32'h0,        32'hC0DE00C7, 1'b1, 32'hC7,  1'b0, 32'h0,   32'h0,        1'b0};
    v[16] = '{1'b0, 1'b0, 32'h47,  32'h0,        32'hC0DE0047, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk("rst_outs_or", |{icache_ready_o, icache_valid_o, icache_dat_o, dcache_ready_o, dcache_valid_o,
                             dcache_dat_o, arvalid, ar, awvalid, aw, wvalid, w, rready}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_ready", {icache_ready_o, dcache_ready_o}, 2'b11);

    for (int i = 0; i < NV; i++) begin
      a0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
      do_req(v[i].port, v[i].we, v[i].addr, v[i].wdat, dat, lat);
      chk($sformatf("v%0d_dat", i), dat, v[i].exp_dat);
      chk($sformatf("v%0d_ar_n", i), ar_cnt - a0, v[i].exp_ar);
      if (v[i].exp_ar) chk($sformatf("v%0d_ar", i), ar_addr, v[i].exp_ar_addr);
      chk($sformatf("v%0d_aw_n", i), aw_cnt - aw0, v[i].exp_aw);
      if (v[i].exp_aw) begin
        chk($sformatf("v%0d_aw", i), aw_addr, v[i].exp_aw_addr);
        chk($sformatf("v%0d_w", i), {w_cnt - w0, w_last}, {32'd1, v[i].exp_w});
      end
      // RESP cycle ends at accept edge + 2, so it is sampled one edge after accept.
      if (v[i].exp_hit) chk($sformatf("v%0d_hit_lat", i), lat, 1);
    end

    // Clean victim in full set 7, memory stalls arready/awready for 5 cycles.
    @(posedge clk); #1 ar_en = 1'b0; aw_en = 1'b0;
    a0 = ar_cnt; aw0 = aw_cnt;
    issue(1'b0, 1'b0, 32'h107, '0, t0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("ar_stall%0d", k), {arvalid, awvalid, icache_valid_o, ar}, {3'b100, 32'h107});
    end
    @(posedge clk); #1 ar_en = 1'b1; aw_en = 1'b1;
    wait_resp(1'b0, dat, tr);
    chk("ar_stall_dat", dat, 32'hC0DE0107);
    chk("ar_stall_cnt", {ar_cnt - a0, aw_cnt - aw0}, {32'd1, 32'd0});

    // Dirty victim (way3, 0xC5) with awready held low.
    @(posedge clk); #1 aw_en = 1'b0;
    a0 = ar_cnt; w0 = w_cnt;
    issue(1'b1, 1'b1, 32'h185, 32'h01850185, t0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("aw_stall%0d", k), {awvalid, wvalid, aw}, {2'b10, 32'hC5});
    end
    @(posedge clk); #1 aw_en = 1'b1;
    wait_resp(1'b1, dat, tr);
    chk("aw_stall_dat", dat, 32'h01850185);
    chk("aw_stall_w", {w_cnt - w0, w_last, ar_cnt - a0}, {32'd1, 32'h00C500C5, 32'd0});

    // Collision: i$ issues two hits, d$ one hit, all raised on the same edge.
    @(posedge clk); #1 order = '0;
    fork
      port_seq(1'b0, 2, 32'h41, 32'hDEADBEEF);
      port_seq(1'b1, 1, 32'h105, 32'h01050105);
      begin
        @(negedge clk); #2;
        chk("coll_ready", {icache_ready_o, dcache_ready_o}, 2'b10);
      end
    join
    #1;
`ifdef L2_RR_ARB_EN
    chk("coll_order", order, 3'b010);
`else
    chk("coll_order", order, 3'b001);
`endif

    // Reset asserted while waiting in R.
    @(posedge clk); #1 r_en = 1'b0;
    issue(1'b0, 1'b0, 32'h207, '0, t0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rready === 1'b1) seen = 1'b1;
    end
    chk("r_state_reached", seen, 1);
    #2 icache_valid_i = 1'b1; icache_addr_i = 32'h41; rst_n = 1'b0;
    #1 chk("rst_mid_outs_or", |{icache_ready_o, icache_valid_o, icache_dat_o, dcache_ready_o, dcache_valid_o,
                                dcache_dat_o, arvalid, ar, awvalid, aw, wvalid, w, rready}, 0);
    repeat (2) @(posedge clk);
    #1 icache_valid_i = 1'b0; r_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_mid_ready", icache_ready_o, 1);
    a0 = ar_cnt;
    do_req(1'b0, 1'b0, 32'h41, '0, dat, lat);
    chk("post_rst_miss", {ar_cnt - a0, ar_addr}, {32'd1, 32'h41});
    chk("post_rst_dat", dat, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
